// File: rtl/mtimer_clint_if.sv
// Register bus between the processor load/store path and the machine timer.
// One access per cycle on bus_sel; read data returns one cycle later with bus_rvalid.
interface mtimer_clint_if;
  logic        bus_sel;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  modport master (
    output bus_sel,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_rvalid
  );

  modport slave (
    input  bus_sel,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_rvalid
  );
endinterface

// File: rtl/mtimer_clint.sv
// RISC-V machine timer: prescaled 64-bit mtime, 64-bit mtimecmp and a registered
// level timer interrupt, programmed over a single-cycle select/write bus.
module mtimer_clint #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  mtimer_clint_if.slave bus,
  output logic          timer_interrupt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TIME_W = 64;
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(PRESCALE - 1);

  localparam logic [1:0] REG_MTIME_LO = 2'd0;
  localparam logic [1:0] REG_MTIME_HI = 2'd1;
  localparam logic [1:0] REG_CMP_LO   = 2'd2;
  localparam logic [1:0] REG_CMP_HI   = 2'd3;

  // Elaboration-time parameter legality
  if (PRESCALE == 0 || PRESCALE > 65535) begin : g_bad_prescale
    $error("mtimer_clint: PRESCALE must be within 1..65535");
  end
  if (CNT_W == 0 || (CNT_W < 64 && (64'(PRESCALE) - 64'd1) >= (64'd1 << CNT_W))) begin : g_bad_cnt_w
    $error("mtimer_clint: CNT_W too narrow to hold PRESCALE-1");
  end

  logic [CNT_W-1:0]  r_presc;
  logic [TIME_W-1:0] r_mtime;
  logic [TIME_W-1:0] r_mtimecmp;
  logic [DATA_W-1:0] r_hi_shadow;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_irq;

  logic              w_tick;
  logic              w_aligned;
  logic              w_wr;
  logic              w_rd;
  logic [1:0]        w_reg;
  logic [CNT_W-1:0]  w_presc_nxt;
  logic [TIME_W-1:0] w_mtime_nxt;
  logic [TIME_W-1:0] w_cmp_nxt;
  logic [DATA_W-1:0] w_shadow_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_rvalid_nxt;
  logic              w_irq_nxt;

  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_aligned = (bus.bus_addr[1:0] == 2'b00);
  assign w_reg     = bus.bus_addr[3:2];
  assign w_wr      = bus.bus_sel & bus.bus_we & w_aligned;
  assign w_rd      = bus.bus_sel & ~bus.bus_we;

  // Next-state: bus writes override the tick increment of the same cycle
  always_comb begin
    w_presc_nxt  = w_tick ? '0 : r_presc + CNT_W'(1);
    w_mtime_nxt  = w_tick ? r_mtime + TIME_W'(1) : r_mtime;
    w_cmp_nxt    = r_mtimecmp;
    w_shadow_nxt = r_hi_shadow;
    w_rdata_nxt  = r_rdata;
    w_rvalid_nxt = w_rd;
    w_irq_nxt    = (r_mtime >= r_mtimecmp);

    if (w_wr) begin
      case (w_reg)
        REG_MTIME_LO: w_mtime_nxt = {r_mtime[TIME_W-1:DATA_W], bus.bus_wdata};
        REG_MTIME_HI: w_mtime_nxt = {bus.bus_wdata, r_mtime[DATA_W-1:0]};
        REG_CMP_LO:   w_cmp_nxt   = {r_mtimecmp[TIME_W-1:DATA_W], bus.bus_wdata};
        REG_CMP_HI:   w_cmp_nxt   = {bus.bus_wdata, r_mtimecmp[DATA_W-1:0]};
        default:      w_cmp_nxt   = r_mtimecmp;
      endcase
    end

    // Reading mtime_lo snapshots the upper half so a following hi read is coherent
    if (w_rd) begin
      w_rdata_nxt = '0;
      if (w_aligned) begin
        case (w_reg)
          REG_MTIME_LO: begin
            w_rdata_nxt  = r_mtime[DATA_W-1:0];
            w_shadow_nxt = r_mtime[TIME_W-1:DATA_W];
          end
          REG_MTIME_HI: w_rdata_nxt = r_hi_shadow;
          REG_CMP_LO:   w_rdata_nxt = r_mtimecmp[DATA_W-1:0];
          REG_CMP_HI:   w_rdata_nxt = r_mtimecmp[TIME_W-1:DATA_W];
          default:      w_rdata_nxt = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc     <= '0;
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_hi_shadow <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_presc     <= w_presc_nxt;
      r_mtime     <= w_mtime_nxt;
      r_mtimecmp  <= w_cmp_nxt;
      r_hi_shadow <= w_shadow_nxt;
      r_rdata     <= w_rdata_nxt;
      r_rvalid    <= w_rvalid_nxt;
      r_irq       <= w_irq_nxt;
    end
  end

  assign bus.bus_rdata    = r_rdata;
  assign bus.bus_rvalid   = r_rvalid;
  assign timer_interrupt  = r_irq;

endmodule
